// File: rtl/nlfm_pulse_receiver.sv
`default_nettype none
// ============================================================================
// Module      : nlfm_pulse_receiver
// Description : Pulse detector with a windowed zero-crossing counter for an
//               offset-binary sample stream. The optional completed-pulse
//               counter is built when NLFM_RX_PULSE_COUNT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module nlfm_pulse_receiver #(
    parameter int THRESH   = 4096,
    parameter int WIN      = 150,
    parameter int IDLE_MIN = 16
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic [15:0] signal,
    output logic        pulse_start,
    output logic        pulse_end,
    output logic [11:0] pulse_len,
    output logic        pulse_long,
    output logic        zc_valid,
    output logic [9:0]  zc_count,
    output logic [15:0] pulse_count
);

    localparam logic [0:0]  c_ST_IDLE   = 1'b0;
    localparam logic [0:0]  c_ST_ACTIVE = 1'b1;
    localparam logic [15:0] c_THRESH    = 16'(THRESH);
    localparam logic [9:0]  c_WIN       = 10'(WIN);
    localparam logic [7:0]  c_IDLE_MIN  = 8'(IDLE_MIN);
    localparam logic [11:0] c_IDLE_LEN  = 12'(IDLE_MIN);
    localparam logic [11:0] c_LEN_MAX   = 12'hFFF;

    logic [0:0]  r_state, w_state_nxt;
    logic [15:0] r_sample;
    logic [11:0] r_len, w_len_nxt;
    logic [9:0]  r_win, w_win_nxt;
    logic [9:0]  r_zc, w_zc_nxt;
    logic [7:0]  r_below, w_below_nxt;
    logic        r_prev, w_prev_nxt;
    logic        r_pulse_start, w_pulse_start_nxt;
    logic        r_pulse_end, w_pulse_end_nxt;
    logic        r_zc_valid, w_zc_valid_nxt;
    logic [9:0]  r_zc_count, w_zc_count_nxt;
    logic [11:0] r_pulse_len, w_pulse_len_nxt;
    logic        r_pulse_long, w_pulse_long_nxt;

    logic [15:0] w_s;
    logic        w_neg;
    logic [15:0] w_mag;
    logic        w_hit;
    logic [11:0] w_len_inc;
    logic        w_len_sat;
    logic [9:0]  w_win_inc;
    logic [9:0]  w_zc_inc;
    logic [7:0]  w_below_inc;
    logic        w_win_done;
    logic        w_quiet_done;

    // Offset binary to two's complement; the most negative code saturates.
    assign w_s   = {~r_sample[15], r_sample[14:0]};
    assign w_neg = w_s[15];
    assign w_mag = (w_s == 16'h8000) ? 16'h7FFF : (w_neg ? (~w_s + 16'd1) : w_s);
    assign w_hit = (w_mag >= c_THRESH);

    assign w_len_inc    = (r_len == c_LEN_MAX) ? r_len : r_len + 12'd1;
    assign w_len_sat    = (w_len_inc == c_LEN_MAX);
    assign w_win_inc    = r_win + 10'd1;
    assign w_zc_inc     = r_zc + {9'd0, w_neg ^ r_prev};
    assign w_below_inc  = w_hit ? 8'd0 : r_below + 8'd1;
    assign w_win_done   = (w_win_inc == c_WIN);
    assign w_quiet_done = (w_below_inc == c_IDLE_MIN);

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_sample      <= 16'h8000;
            r_state       <= c_ST_IDLE;
            r_len         <= '0;
            r_win         <= '0;
            r_zc          <= '0;
            r_below       <= '0;
            r_prev        <= 1'b0;
            r_pulse_start <= 1'b0;
            r_pulse_end   <= 1'b0;
            r_zc_valid    <= 1'b0;
            r_zc_count    <= '0;
            r_pulse_len   <= '0;
            r_pulse_long  <= 1'b0;
        end else begin
            r_sample      <= signal;
            r_state       <= w_state_nxt;
            r_len         <= w_len_nxt;
            r_win         <= w_win_nxt;
            r_zc          <= w_zc_nxt;
            r_below       <= w_below_nxt;
            r_prev        <= w_prev_nxt;
            r_pulse_start <= w_pulse_start_nxt;
            r_pulse_end   <= w_pulse_end_nxt;
            r_zc_valid    <= w_zc_valid_nxt;
            r_zc_count    <= w_zc_count_nxt;
            r_pulse_len   <= w_pulse_len_nxt;
            r_pulse_long  <= w_pulse_long_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE:   if (w_hit)        w_state_nxt = c_ST_ACTIVE;
            c_ST_ACTIVE: if (w_quiet_done) w_state_nxt = c_ST_IDLE;
            default:                       w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_comb begin
        w_len_nxt         = r_len;
        w_win_nxt         = r_win;
        w_zc_nxt          = r_zc;
        w_below_nxt       = r_below;
        w_prev_nxt        = r_prev;
        w_pulse_start_nxt = 1'b0;
        w_pulse_end_nxt   = 1'b0;
        w_zc_valid_nxt    = 1'b0;
        w_zc_count_nxt    = r_zc_count;
        w_pulse_len_nxt   = r_pulse_len;
        w_pulse_long_nxt  = r_pulse_long;
        case (r_state)
            c_ST_IDLE: begin
                if (w_hit) begin
                    w_pulse_start_nxt = 1'b1;
                    w_len_nxt         = 12'd1;
                    w_win_nxt         = 10'd1;
                    w_zc_nxt          = '0;
                    w_below_nxt       = '0;
                    w_prev_nxt        = w_neg;
                end
            end
            c_ST_ACTIVE: begin
                w_len_nxt   = w_len_inc;
                w_win_nxt   = w_win_inc;
                w_zc_nxt    = w_zc_inc;
                w_below_nxt = w_below_inc;
                w_prev_nxt  = w_neg;
                if (w_win_done) begin
                    w_zc_valid_nxt = 1'b1;
                    w_zc_count_nxt = w_zc_inc;
                    w_win_nxt      = '0;
                    w_zc_nxt       = '0;
                end
                // Trailing quiet samples are not part of the reported length.
                if (w_quiet_done) begin
                    w_pulse_end_nxt  = 1'b1;
                    w_pulse_len_nxt  = w_len_sat ? c_LEN_MAX : w_len_inc - c_IDLE_LEN;
                    w_pulse_long_nxt = w_len_sat;
                    w_len_nxt        = '0;
                    w_win_nxt        = '0;
                    w_zc_nxt         = '0;
                    w_below_nxt      = '0;
                end
            end
            default: ;
        endcase
    end

`ifdef NLFM_RX_PULSE_COUNT_EN
    logic [15:0] r_pulse_count;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_pulse_count <= '0;
        end else if (w_pulse_end_nxt) begin
            r_pulse_count <= r_pulse_count + 16'd1;
        end
    end

    assign pulse_count = r_pulse_count;
`else
    assign pulse_count = '0;
`endif

    assign pulse_start = r_pulse_start;
    assign pulse_end   = r_pulse_end;
    assign pulse_len   = r_pulse_len;
    assign pulse_long  = r_pulse_long;
    assign zc_valid    = r_zc_valid;
    assign zc_count    = r_zc_count;

endmodule
`default_nettype wire

// File: tb/tb_nlfm_pulse_receiver.sv
`default_nettype none
// ============================================================================
// Module      : tb_nlfm_pulse_receiver
// Description : Scoreboard bench for nlfm_pulse_receiver; expected strobe
//               events are queued by the stimulus and matched by a monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nlfm_pulse_receiver;

    logic        CLOCK_50;
    logic        reset;
    logic [15:0] signal;
    logic        pulse_start;
    logic        pulse_end;
    logic [11:0] pulse_len;
    logic        pulse_long;
    logic        zc_valid;
    logic [9:0]  zc_count;
    logic [15:0] pulse_count;

    nlfm_pulse_receiver dut (
        .CLOCK_50    (CLOCK_50),
        .reset       (reset),
        .signal      (signal),
        .pulse_start (pulse_start),
        .pulse_end   (pulse_end),
        .pulse_len   (pulse_len),
        .pulse_long  (pulse_long),
        .zc_valid    (zc_valid),
        .zc_count    (zc_count),
        .pulse_count (pulse_count)
    );

    typedef struct {
        int at;
        bit st;
        bit en;
        bit zv;
        int zc;
        int len;
        bit lng;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   c0     = 0;
    int   exp_cnt;

    initial CLOCK_50 = 1'b0;
    always #10 CLOCK_50 = ~CLOCK_50;

    always @(posedge CLOCK_50) cyc <= cyc + 1;

    function automatic void chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Event is expected on the output edge two cycles after sample k is driven.
    function automatic void push(input int k, input bit st, input bit en, input bit zv,
                                 input int zc, input int len, input bit lng);
        exp_q.push_back('{c0 + k + 1, st, en, zv, zc, len, lng});
    endfunction

    always @(negedge CLOCK_50) begin
        if (pulse_start || pulse_end || zc_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_event: start=%0b end=%0b zcv=%0b at cycle %0d, expected none",
                         pulse_start, pulse_end, zc_valid, cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("event_cycle", cyc, e.at);
                chk("event_start", int'(pulse_start), int'(e.st));
                chk("event_end", int'(pulse_end), int'(e.en));
                chk("event_zcv", int'(zc_valid), int'(e.zv));
                if (e.zv) chk("zc_count", int'(zc_count), e.zc);
                if (e.en) begin
                    chk("pulse_len", int'(pulse_len), e.len);
                    chk("pulse_long", int'(pulse_long), int'(e.lng));
                end
            end
        end
    end

    task automatic drive(input logic [15:0] v);
        signal = v;
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic hold(input logic [15:0] v, input int n);
        for (int k = 0; k < n; k++) drive(v);
    endtask

    // Square wave, 10 samples at 40000 then 10 at 25000, from pulse sample 1.
    task automatic sq(input int n);
        for (int k = 0; k < n; k++) drive(((k / 10) % 2 == 0) ? 16'd40000 : 16'd25000);
    endtask

    initial begin
        #10ms;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        signal = 16'd32768;
        reset  = 1'b1;
        repeat (3) @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        chk("rst_pulse_start", int'(pulse_start), 0);
        chk("rst_pulse_end", int'(pulse_end), 0);
        chk("rst_zc_valid", int'(zc_valid), 0);
        chk("rst_pulse_len", int'(pulse_len), 0);
        chk("rst_pulse_long", int'(pulse_long), 0);
        chk("rst_zc_count", int'(zc_count), 0);
        chk("rst_pulse_count", int'(pulse_count), 0);
        @(posedge CLOCK_50);
        #1;
        reset = 1'b0;

        // Mid-scale input must never trigger anything.
        hold(16'd32768, 1000);
        chk("idle_pulse_len", int'(pulse_len), 0);
        chk("idle_zc_count", int'(zc_count), 0);
        chk("idle_pulse_count", int'(pulse_count), 0);

        // 300-sample square pulse: windows of 14 and 15 crossings.
        c0 = cyc;
        push(1,   1, 0, 0, 0,  0,   0);
        push(150, 0, 0, 1, 14, 0,   0);
        push(300, 0, 0, 1, 15, 0,   0);
        push(316, 0, 1, 0, 0,  300, 0);
        sq(300);
        hold(16'd32768, 21);
        chk("held_pulse_len", int'(pulse_len), 300);
        chk("held_zc_count", int'(zc_count), 15);
        chk("held_pulse_long", int'(pulse_long), 0);

        // Long constant pulse saturates the length counter.
        c0 = cyc;
        push(1, 1, 0, 0, 0, 0, 0);
        for (int w = 1; w <= 33; w++) push(150 * w, 0, 0, 1, 0, 0, 0);
        push(5016, 0, 1, 0, 0, 4095, 1);
        hold(16'd40000, 5000);
        hold(16'd32768, 20);
`ifdef NLFM_RX_PULSE_COUNT_EN
        exp_cnt = 2;
`else
        exp_cnt = 0;
`endif
        chk("pulse_count_two", int'(pulse_count), exp_cnt);

        // Reset in the middle of a pulse abandons it silently.
        c0 = cyc;
        push(1, 1, 0, 0, 0, 0, 0);
        sq(99);
        reset = 1'b1;
        drive(16'd25000);
        reset = 1'b0;
        chk("midrst_pulse_len", int'(pulse_len), 0);
        chk("midrst_pulse_long", int'(pulse_long), 0);
        chk("midrst_zc_count", int'(zc_count), 0);
        chk("midrst_pulse_count", int'(pulse_count), 0);
        c0 = cyc;
        push(1,   1, 0, 0, 0,  0,   0);
        push(150, 0, 0, 1, 14, 0,   0);
        push(300, 0, 0, 1, 15, 0,   0);
        push(316, 0, 1, 0, 0,  300, 0);
        sq(300);
        hold(16'd32768, 21);

        // 134 active + 16 quiet: window and pulse end land on sample 150.
        // Crossing into the quiet tail counts, giving 14.
        c0 = cyc;
        push(1,   1, 0, 0, 0,  0,   0);
        push(150, 0, 1, 1, 14, 134, 0);
        sq(134);
        hold(16'd32768, 21);

        // A short dip shorter than IDLE_MIN must not end the pulse.
        c0 = cyc;
        push(1,  1, 0, 0, 0, 0,  0);
        push(66, 0, 1, 0, 0, 50, 0);
        hold(16'd40000, 20);
        hold(16'd32768, 10);
        hold(16'd40000, 20);
        hold(16'd32768, 21);
        chk("dip_held_zc_count", int'(zc_count), 14);
        chk("dip_pulse_len", int'(pulse_len), 50);
`ifdef NLFM_RX_PULSE_COUNT_EN
        exp_cnt = 3;
`else
        exp_cnt = 0;
`endif
        chk("pulse_count_three", int'(pulse_count), exp_cnt);

        hold(16'd32768, 10);
        while (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checks++;
            errors++;
            $display("FAIL missing_event: nothing seen, expected event due at cycle %0d", e.at);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
